alu_rs: RTL and testbench

Reservation station for the integer ALU, directly downstream of `dispatch`. It accepts up to PIPE_WIDTH renamed instructions per cycle on the `alu_rs_*` write ports, snoops the CDB to wake up pending source operands, and issues the oldest fully-ready entry (one per cycle) to the ALU. The queue is collapsing: entry 0 is always the oldest.

---
 rtl/alu_rs.sv | 127 ++++++++++++
 tb/tb_alu_rs.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// Integer ALU reservation station: collapsing queue, oldest-ready issue, CDB wakeup.
// Optional ALU_RS_DISPATCH_WAKEUP_EN also wakes operands on the dispatch write path.
package alu_rs_pkg;
  localparam int PIPE_WIDTH = 2;
  localparam int ROB_TAG_W  = 6;

  typedef struct packed {
    logic [3:0]           op;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic                 src_0_ready;
    logic [ROB_TAG_W-1:0] src_0_tag;
    logic [31:0]          src_0_data;
    logic                 src_1_ready;
    logic [ROB_TAG_W-1:0] src_1_tag;
    logic [31:0]          src_1_data;
  } instruction_t;
endpackage

module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_CDB     = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  output logic [PIPE_WIDTH-1:0]               alu_rs_rdy,
  input  logic [PIPE_WIDTH-1:0]               alu_rs_we,
  input  instruction_t [PIPE_WIDTH-1:0]       alu_rs_entries,
  input  logic [NUM_CDB-1:0]                  cdb_valid,
  input  logic [NUM_CDB-1:0][ROB_TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB-1:0][31:0]            cdb_data,
  output logic                                issue_valid,
  input  logic                                issue_rdy,
  output instruction_t                        issue_inst
);

  localparam int CW = $clog2(NUM_ENTRIES + 1);
  localparam int IW = $clog2(NUM_ENTRIES);

  instruction_t   q   [NUM_ENTRIES];
  instruction_t   q_n [NUM_ENTRIES];
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;
  logic [CW-1:0]  pos;
  logic [IW-1:0]  sel;
  logic           fire;

  // Ports scanned high to low so the lowest matching port lands last.
  function automatic instruction_t wake(
    input instruction_t                      e,
    input logic [NUM_CDB-1:0]                v,
    input logic [NUM_CDB-1:0][ROB_TAG_W-1:0] t,
    input logic [NUM_CDB-1:0][31:0]          d
  );
    instruction_t w;
    w = e;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (!e.src_0_ready && v[k] && t[k] == e.src_0_tag) begin
        w.src_0_ready = 1'b1;
        w.src_0_data  = d[k];
      end
      if (!e.src_1_ready && v[k] && t[k] == e.src_1_tag) begin
        w.src_1_ready = 1'b1;
        w.src_1_data  = d[k];
      end
    end
    return w;
  endfunction

  for (genvar p = 0; p < PIPE_WIDTH; p++) begin : g_rdy
    assign alu_rs_rdy[p] = cnt <= CW'(NUM_ENTRIES - 1 - p);
  end

  always_comb begin
    issue_valid = 1'b0;
    sel         = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (i < int'(cnt) && q[i].src_0_ready && q[i].src_1_ready) begin
        issue_valid = 1'b1;
        sel         = IW'(i);
      end
    end
    issue_inst = issue_valid ? q[sel] : '0;
  end

  // Survivors are compacted first, then dispatch slots append at the tail.
  always_comb begin
    fire = issue_valid && issue_rdy;
    pos  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) q_n[i] = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (i < int'(cnt) && !(fire && IW'(i) == sel)) begin
        q_n[pos[IW-1:0]] = wake(q[i], cdb_valid, cdb_tag, cdb_data);
        pos = pos + CW'(1);
      end
    end
    for (int s = 0; s < PIPE_WIDTH; s++) begin
      if (alu_rs_we[s] && pos < CW'(NUM_ENTRIES)) begin
`ifdef ALU_RS_DISPATCH_WAKEUP_EN
        q_n[pos[IW-1:0]] = wake(alu_rs_entries[s], cdb_valid,
                                cdb_tag, cdb_data);
`else
        q_n[pos[IW-1:0]] = alu_rs_entries[s];
`endif
        pos = pos + CW'(1);
      end
    end
    cnt_n = pos;
    if (flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) q_n[i] = '0;
      cnt_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) q[i] <= '0;
    end else begin
      cnt <= cnt_n;
      for (int i = 0; i < NUM_ENTRIES; i++) q[i] <= q_n[i];
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs.
// Honors ALU_RS_DISPATCH_WAKEUP_EN for the dispatch/broadcast race case.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [1:0]           rdy;
  logic [1:0]           we;
  instruction_t [1:0]   ent;
  logic [1:0]           cv;
  logic [1:0][5:0]      ct;
  logic [1:0][31:0]     cd;
  logic                 iv;
  logic                 ir;
  instruction_t         ii;

  int errs   = 0;
  int checks = 0;

  alu_rs #(.NUM_ENTRIES(8), .NUM_CDB(2)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .alu_rs_rdy(rdy),
    .alu_rs_we(we),
    .alu_rs_entries(ent),
    .cdb_valid(cv),
    .cdb_tag(ct),
    .cdb_data(cd),
    .issue_valid(iv),
    .issue_rdy(ir),
    .issue_inst(ii)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic instruction_t mk(
    input logic [3:0] op, input logic [5:0] rob,
    input logic r0, input logic [5:0] t0, input logic [31:0] d0,
    input logic r1, input logic [5:0] t1, input logic [31:0] d1);
    instruction_t x;
    x.op = op; x.rob_tag = rob;
    x.src_0_ready = r0; x.src_0_tag = t0; x.src_0_data = d0;
    x.src_1_ready = r1; x.src_1_tag = t1; x.src_1_data = d1;
    return x;
  endfunction

  // Dispatch must never write more slots than rdy advertises.
  always @(posedge clk) begin
    if (!rst && !flush && we != 2'b00)
      chk("wcap", 128'(($countones(we)) <=
          (rdy[1] ? 2 : (rdy[0] ? 1 : 0))), 128'd1);
  end

  instruction_t a, b, e0, e1;

  initial begin
    rst = 1'b1; flush = 1'b0; we = '0; ent = '0;
    cv = '0; ct = '0; cd = '0; ir = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_rdy", 128'(rdy), 128'(2'b11));
    chk("rst_iv", 128'(iv), 128'd0);
    chk("rst_inst", 128'(ii), 128'd0);

    // two ready ADDs, in-order issue
    a = mk(4'd1, 6'd1, 1'b1, 6'd0, 32'd10, 1'b1, 6'd0, 32'd20);
    b = mk(4'd1, 6'd2, 1'b1, 6'd0, 32'd11, 1'b1, 6'd0, 32'd21);
    ent[0] = a; ent[1] = b; we = 2'b11;
    step();
    we = '0;
    chk("add_iv", 128'(iv), 128'd1);
    chk("add_a", 128'(ii), 128'(a));
    ir = 1'b1;
    step();
    chk("add_b_iv", 128'(iv), 128'd1);
    chk("add_b", 128'(ii), 128'(b));
    step();
    ir = 1'b0;
    chk("add_empty", 128'(iv), 128'd0);

    // fill to 8 waiting on tag 5
    for (int c = 0; c < 3; c++) begin
      ent[0] = mk(4'd2, 6'(10 + 2 * c), 1'b0, 6'd5, 32'd0,
                  1'b1, 6'd0, 32'(c));
      ent[1] = mk(4'd2, 6'(11 + 2 * c), 1'b0, 6'd5, 32'd0,
                  1'b1, 6'd0, 32'(c));
      we = 2'b11;
      step();
    end
    we = '0;
    chk("fill_rdy6", 128'(rdy), 128'(2'b11));
    ent[0] = mk(4'd2, 6'd16, 1'b0, 6'd5, 32'd0, 1'b1, 6'd0, 32'd6);
    we = 2'b01;
    step();
    we = '0;
    chk("fill_rdy7", 128'(rdy), 128'(2'b01));
    ent[0] = mk(4'd2, 6'd17, 1'b0, 6'd5, 32'd0, 1'b1, 6'd0, 32'd7);
    we = 2'b01;
    step();
    we = '0;
    chk("fill_rdy8", 128'(rdy), 128'(2'b00));
    chk("fill_iv", 128'(iv), 128'd0);
    cv = 2'b11;
    ct[0] = 6'd7; cd[0] = 32'h0000_0077;
    ct[1] = 6'd5; cd[1] = 32'hDEAD_BEEF;
    chk("cdb_same_cyc", 128'(iv), 128'd0);
    step();
    cv = '0;
    chk("cdb_iv", 128'(iv), 128'd1);
    chk("cdb_rob", 128'(ii.rob_tag), 128'd10);
    chk("cdb_data", 128'(ii.src_0_data), 128'hDEAD_BEEF);
    ir = 1'b1;
    step();
    chk("cdb_next", 128'(ii.rob_tag), 128'd11);
    step();
    ir = 1'b0;
    chk("cnt6_rdy", 128'(rdy), 128'(2'b11));

    // flush beats same-cycle writes
    flush = 1'b1;
    ent[0] = a; ent[1] = b; we = 2'b11;
    step();
    flush = 1'b0; we = '0;
    chk("flush_rdy", 128'(rdy), 128'(2'b11));
    chk("flush_iv", 128'(iv), 128'd0);
    chk("flush_inst", 128'(ii), 128'd0);
    step();
    chk("flush_stay", 128'(iv), 128'd0);

    // out-of-order issue around a waiting head
    e0 = mk(4'd3, 6'd20, 1'b0, 6'd3, 32'd0, 1'b1, 6'd0, 32'd1);
    e1 = mk(4'd3, 6'd21, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd6);
    ent[0] = e0; ent[1] = e1; we = 2'b11; ir = 1'b1;
    step();
    we = '0;
    chk("ooo_first", 128'(ii.rob_tag), 128'd21);
    step();
    chk("ooo_wait", 128'(iv), 128'd0);
    cv = 2'b11;
    ct[0] = 6'd3; cd[0] = 32'h33;
    ct[1] = 6'd3; cd[1] = 32'h44;
    step();
    cv = '0;
    chk("ooo_iv", 128'(iv), 128'd1);
    chk("ooo_rob", 128'(ii.rob_tag), 128'd20);
    chk("ooo_prio", 128'(ii.src_0_data), 128'h33);
    step();
    ir = 1'b0;
    chk("ooo_empty", 128'(iv), 128'd0);

    // issue + we=2'b10 at cnt=4
    for (int c = 0; c < 2; c++) begin
      ent[0] = mk(4'd5, 6'(30 + 2 * c), 1'b1, 6'd0, 32'd0,
                  1'b1, 6'd0, 32'd0);
      ent[1] = mk(4'd5, 6'(31 + 2 * c), 1'b1, 6'd0, 32'd0,
                  1'b1, 6'd0, 32'd0);
      we = 2'b11;
      step();
    end
    ent[0] = mk(4'd5, 6'd41, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    ent[1] = mk(4'd5, 6'd40, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    we = 2'b10; ir = 1'b1;
    step();
    we = '0;
    chk("mix_0", 128'(ii.rob_tag), 128'd31);
    step();
    chk("mix_1", 128'(ii.rob_tag), 128'd32);
    step();
    chk("mix_2", 128'(ii.rob_tag), 128'd33);
    step();
    chk("mix_3", 128'(ii.rob_tag), 128'd40);
    step();
    ir = 1'b0;
    chk("mix_empty", 128'(iv), 128'd0);

    // asynchronous reset mid-operation
    ent[0] = mk(4'd6, 6'd60, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    we = 2'b01;
    step();
    we = '0;
    chk("arst_pre", 128'(iv), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_iv", 128'(iv), 128'd0);
    chk("arst_rdy", 128'(rdy), 128'(2'b11));
    chk("arst_inst", 128'(ii), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // dispatch/broadcast race on tag 9
    ent[0] = mk(4'd4, 6'd50, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd0);
    we = 2'b01;
    cv = 2'b01; ct[0] = 6'd9; cd[0] = 32'h99;
    step();
    we = '0; cv = '0;
`ifdef ALU_RS_DISPATCH_WAKEUP_EN
    chk("race_iv", 128'(iv), 128'd1);
    chk("race_data", 128'(ii.src_0_data), 128'h99);
    ir = 1'b1;
    step();
    ir = 1'b0;
    chk("race_gone", 128'(iv), 128'd0);
`else
    $display("note: tag 9 written not-ready during its broadcast (illegal race stimulus)");
    chk("race_stuck", 128'(iv), 128'd0);
    ir = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("race_stuck", 128'(iv), 128'd0);
    end
    ir = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("race_flush", 128'(rdy), 128'(2'b11));
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
